div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one fixed-point divider (2..16).
REQ-002 SHALL have parameter N, default 33, operand width, sign-magnitude (MSB = sign).
REQ-003 SHALL have parameter Q, default 33, quotient fractional width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_req  in  NREQ  per-requester request, held until granted.
REQ-007 SHALL have port i_req_dividend  in  NREQ*N  packed dividends, slot k = bits [k*N +: N].
REQ-008 SHALL have port i_req_divisor  in  NREQ*N  packed divisors, same packing.
REQ-009 SHALL have port o_gnt  out  NREQ  one-hot grant pulse.
REQ-010 SHALL have ports o_div_start (out 1), o_div_dividend (out N), o_div_divisor (out N), i_div_complete (in 1, high = divider idle/done), i_div_quot_int (in N), i_div_quot_frac (in Q).
REQ-011 SHALL have ports o_rsp_valid (out 1), i_rsp_ready (in 1), o_rsp_id (out clog2(NREQ)), o_rsp_quot_int (out N), o_rsp_quot_frac (out Q), o_rsp_dbz (out 1, divide-by-zero flag).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, BUSY, RESP.
REQ-013 IDLE with any i_req bit and i_div_complete=1 SHALL select the winner by round-robin, capture its operands and id, and go to ISSUE next cycle.
REQ-014 Round-robin SHALL search upward from (last granted id + 1) mod NREQ; the pointer after reset SHALL be NREQ-1, so id 0 wins first.
REQ-015 ISSUE SHALL last exactly one cycle, asserting o_gnt[id]=1 and o_div_start=1 with the captured operands on o_div_dividend/o_div_divisor; next state WAIT_ACK.
REQ-016 WAIT_ACK SHALL hold until i_div_complete=0, then go to BUSY; BUSY SHALL hold until i_div_complete=1, then register the quotient and go to RESP.
REQ-017 o_div_start SHALL never be 1 outside ISSUE, and ISSUE SHALL never be entered while i_div_complete=0.
REQ-018 o_div_dividend/o_div_divisor SHALL stay stable from ISSUE until leaving BUSY.
REQ-019 RESP SHALL assert o_rsp_valid with id, quotient and dbz stable until i_rsp_ready=1; on that cycle the next state SHALL be IDLE.
REQ-020 Scheduler overhead SHALL be 1 cycle (IDLE->ISSUE) before start plus 1 cycle (BUSY->RESP) after divider completion; back-to-back: a new ISSUE no earlier than 1 cycle after the RESP handshake.
REQ-021 Requests deasserted before grant SHALL be dropped without side effects; a request arriving while busy SHALL wait, losing no more than NREQ-1 grants.

Reset
REQ-022 On rst_n=0 at a clock edge, state SHALL become IDLE; o_gnt, o_div_start, o_rsp_valid, o_rsp_dbz SHALL be 0; o_rsp_id, quotient and operand registers 0; rr pointer NREQ-1.
REQ-023 Reset mid-operation SHALL abandon the transaction with no response; the divider SHALL share rst_n.

Configuration
REQ-024 Macro DIV_SCHED_DBZ_BYPASS_EN defined: divisor magnitude (bits N-2:0) zero SHALL skip ISSUE/WAIT_ACK/BUSY (o_gnt still pulses one cycle), go to RESP with o_rsp_dbz=1, o_rsp_quot_int magnitude all ones, sign = XOR of operand signs, o_rsp_quot_frac all ones.
REQ-025 Macro undefined: zero divisors SHALL be issued to the divider normally and o_rsp_dbz SHALL be tied 0.

Structure
REQ-026 Package div_sched_pkg SHALL hold the FSM state enum and default N/Q constants.
REQ-027 Sub-module rr_arbiter (NREQ-wide request, rotating priority, one-hot grant, pointer-update enable) SHALL implement the arbitration.

Verification
REQ-028 Single req id 0, dividend 1034, divisor 2345, positive -> one start pulse, o_rsp_id=0, quot_int=0, frac = floor(1034*2^33/2345).
REQ-029 All four i_req high from reset -> grants in order 0,1,2,3,0; each response id matches grant order.
REQ-030 i_rsp_ready held 0 for 20 cycles in RESP -> o_rsp_valid and data stable, no o_div_start issued.
REQ-031 rst_n=0 for 1 cycle during BUSY -> next cycle IDLE, all outputs 0, no response for that request.
REQ-032 With DIV_SCHED_DBZ_BYPASS_EN, dividend -5 (sign set), divisor +0 -> no o_div_start, o_rsp_dbz=1, quot_int sign 1 and magnitude all ones; without macro -> divider started, o_rsp_dbz=0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// ============================================================================
// Module  : div_sched_pkg
// Purpose : Shared types and default sizes for the divider scheduler.
//           Holds the scheduler FSM state encoding and the default
//           requester count, operand width and quotient fraction width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_sched_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_N    = 33;
  localparam int DEF_Q    = 33;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_BUSY     = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_sched_if.sv
// ============================================================================
// Module  : div_sched_if
// Purpose : Bundles the requester, divider and response signals of the
//           divider scheduler.
// Ports   : slave  - the scheduler side (drives o_* signals)
//           master - the environment side (requesters, divider, consumer)
//           Requester : i_req, i_req_dividend, i_req_divisor, o_gnt
//           Divider   : o_div_start, o_div_dividend, o_div_divisor,
//                       i_div_complete, i_div_quot_int, i_div_quot_frac
//           Response  : o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_quot_int,
//                       o_rsp_quot_frac, o_rsp_dbz
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_sched_if
  import div_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int N    = DEF_N,
  parameter int Q    = DEF_Q
);
  localparam int IDW = $clog2(NREQ);

  // requesters
  logic [NREQ-1:0]   i_req;
  logic [NREQ*N-1:0] i_req_dividend;
  logic [NREQ*N-1:0] i_req_divisor;
  logic [NREQ-1:0]   o_gnt;
  // divider
  logic              o_div_start;
  logic [N-1:0]      o_div_dividend;
  logic [N-1:0]      o_div_divisor;
  logic              i_div_complete;
  logic [N-1:0]      i_div_quot_int;
  logic [Q-1:0]      i_div_quot_frac;
  // response
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [IDW-1:0]    o_rsp_id;
  logic [N-1:0]      o_rsp_quot_int;
  logic [Q-1:0]      o_rsp_quot_frac;
  logic              o_rsp_dbz;

  modport slave (
    input  i_req, i_req_dividend, i_req_divisor,
    output o_gnt,
    output o_div_start, o_div_dividend, o_div_divisor,
    input  i_div_complete, i_div_quot_int, i_div_quot_frac,
    output o_rsp_valid, o_rsp_id, o_rsp_quot_int, o_rsp_quot_frac, o_rsp_dbz,
    input  i_rsp_ready
  );

  modport master (
    output i_req, i_req_dividend, i_req_divisor,
    input  o_gnt,
    input  o_div_start, o_div_dividend, o_div_divisor,
    output i_div_complete, i_div_quot_int, i_div_quot_frac,
    input  o_rsp_valid, o_rsp_id, o_rsp_quot_int, o_rsp_quot_frac, o_rsp_dbz,
    output i_rsp_ready
  );

endinterface

`default_nettype wire

// File: rtl/div_sched_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Rotating-priority arbiter. The search starts one above the last
//           granted id and wraps; the pointer moves only when i_update is
//           high, so a grant that is not taken does not disturb fairness.
// Ports   : clk, rst_n   - clock, synchronous active-low reset
//           i_req        - request vector
//           i_update     - commit the current winner as last granted
//           o_gnt        - one-hot winner (combinational)
//           o_gnt_id     - encoded winner
//           o_valid      - at least one request present
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic                    i_update,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_gnt_id,
  output logic                    o_valid
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] win;
  logic            found;

  // Walk ptr+1 .. ptr+NREQ (mod NREQ); the first set request wins.
  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!found && i_req[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
    if (found) begin
      win[win_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_update && found) begin
      ptr_d = win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IDW'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_gnt    = win;
  assign o_gnt_id = win_id;
  assign o_valid  = found;

endmodule

`default_nettype wire

// File: rtl/div_sched.sv
// ============================================================================
// Module  : div_sched
// Purpose : Shares one fixed-point sign-magnitude divider among NREQ
//           requesters. A round-robin winner is captured in IDLE, issued to
//           the divider for one cycle, tracked until the divider reports
//           completion, and its quotient is held on the response port until
//           accepted.
// Ports   : clk    - clock, rising edge
//           rst_n  - synchronous active-low reset (shared with the divider)
//           bus    - div_sched_if.slave (requests, divider, response)
// Config  : DIV_SCHED_DBZ_BYPASS_EN - when defined, a zero divisor magnitude
//           is answered directly with a saturated quotient and o_rsp_dbz=1,
//           without starting the divider. Undefined: zero divisors go to the
//           divider and o_rsp_dbz is 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sched
  import div_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int N    = DEF_N,
  parameter int Q    = DEF_Q
) (
  input  logic    clk,
  input  logic    rst_n,
  div_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [N-1:0]    dividend_q, dividend_d;
  logic [N-1:0]    divisor_q, divisor_d;
  logic [N-1:0]    quot_int_q, quot_int_d;
  logic [Q-1:0]    quot_frac_q, quot_frac_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
  logic            dbz_q, dbz_d;
`endif

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_valid;
  logic            take;
  logic [N-1:0]    sel_dividend;
  logic [N-1:0]    sel_divisor;

  // A winner is only taken while the divider is idle, so ISSUE can never be
  // entered with a busy divider.
  assign take = (state_q == ST_IDLE) && arb_valid && bus.i_div_complete;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (bus.i_req),
    .i_update (take),
    .o_gnt    (arb_gnt),
    .o_gnt_id (arb_id),
    .o_valid  (arb_valid)
  );

  assign sel_dividend = bus.i_req_dividend[arb_id*N +: N];
  assign sel_divisor  = bus.i_req_divisor[arb_id*N +: N];

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quot_int_d  = quot_int_q;
    quot_frac_d = quot_frac_q;
    gnt_d       = '0;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          id_d       = arb_id;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          // Grant is registered: it lands in ISSUE, or in the first RESP
          // cycle of a bypassed divide-by-zero.
          gnt_d      = arb_gnt;
          state_d    = ST_ISSUE;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
          dbz_d      = 1'b0;
          if (sel_divisor[N-2:0] == '0) begin
            state_d     = ST_RESP;
            dbz_d       = 1'b1;
            quot_int_d  = {sel_dividend[N-1] ^ sel_divisor[N-1], {(N-1){1'b1}}};
            quot_frac_d = '1;
          end
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Wait for the divider to acknowledge the start by going busy.
        if (!bus.i_div_complete) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.i_div_complete) begin
          quot_int_d  = bus.i_div_quot_int;
          quot_frac_d = bus.i_div_quot_frac;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quot_int_q  <= '0;
      quot_frac_q <= '0;
      gnt_q       <= '0;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quot_int_q  <= quot_int_d;
      quot_frac_q <= quot_frac_d;
      gnt_q       <= gnt_d;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.o_gnt           = gnt_q;
  assign bus.o_div_start     = (state_q == ST_ISSUE);
  assign bus.o_div_dividend  = dividend_q;
  assign bus.o_div_divisor   = divisor_q;
  assign bus.o_rsp_valid     = (state_q == ST_RESP);
  assign bus.o_rsp_id        = id_q;
  assign bus.o_rsp_quot_int  = quot_int_q;
  assign bus.o_rsp_quot_frac = quot_frac_q;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
  assign bus.o_rsp_dbz       = dbz_q;
`else
  assign bus.o_rsp_dbz       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_sched.sv
// ============================================================================
// Module  : tb_div_sched
// Purpose : Self-checking bench for div_sched with a behavioural
//           sign-magnitude fixed-point divider (latency LAT cycles).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_sched;

  localparam int NREQ = 4;
  localparam int N    = 33;
  localparam int Q    = 33;
  localparam int LAT  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_sched_if #(.NREQ(NREQ), .N(N), .Q(Q)) bus ();

  div_sched #(.NREQ(NREQ), .N(N), .Q(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int gnt_cnt [NREQ] = '{default: 0};

  // --------------------------------------------------------------------------
  // divider model: 65-bit magnitude quotient = (|a| << 33) / |b|
  // zero divisor saturates to all ones
  // --------------------------------------------------------------------------
  function automatic logic [65:0] fx_div(input logic [32:0] a, input logic [32:0] b);
    logic [64:0] num;
    logic [64:0] q;
    if (b[31:0] == 32'd0) begin
      return {a[32] ^ b[32], {65{1'b1}}};
    end
    num = {a[31:0], 33'd0};
    q   = num / {33'd0, b[31:0]};
    return {a[32] ^ b[32], q};
  endfunction

  logic [N-1:0] m_dvd, m_dvs;
  int           m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.i_div_complete  <= 1'b1;
      bus.i_div_quot_int  <= '0;
      bus.i_div_quot_frac <= '0;
      m_cnt               <= 0;
    end else if (bus.i_div_complete) begin
      if (bus.o_div_start) begin
        bus.i_div_complete <= 1'b0;
        m_cnt              <= LAT;
        m_dvd              <= bus.o_div_dividend;
        m_dvs              <= bus.o_div_divisor;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        bus.i_div_complete <= 1'b1;
        {bus.i_div_quot_int, bus.i_div_quot_frac} <= fx_div(m_dvd, m_dvs);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.o_div_start === 1'b1) starts <= starts + 1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.o_gnt[k] === 1'b1) gnt_cnt[k] <= gnt_cnt[k] + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.o_gnt == '0 && cyc < 200);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.o_rsp_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake();
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    bus.i_req_dividend[id*N +: N] = dvd;
    bus.i_req_divisor[id*N +: N]  = dvs;
  endtask

  // one complete transaction, optionally stalling the response
  task automatic run_one(input int tag, input int id,
                         input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [N-1:0] e_int, input logic [Q-1:0] e_frac,
                         input logic e_dbz, input int e_start, input int stall);
    int              s0, s_mid, cyc;
    logic [NREQ-1:0] onehot;
    bit              stable;
    s0 = starts;
    set_ops(id, dvd, dvs);
    bus.i_req[id] = 1'b1;
    wait_gnt(cyc);
    onehot     = '0;
    onehot[id] = 1'b1;
    chk($sformatf("v%0d_gnt", tag), 64'(bus.o_gnt), 64'(onehot));
    bus.i_req[id] = 1'b0;
    wait_valid(cyc);
    chk($sformatf("v%0d_latency", tag), 64'(cyc), 64'((e_start != 0) ? LAT + 2 : 0));
    chk($sformatf("v%0d_id", tag), 64'(bus.o_rsp_id), 64'(id));
    chk($sformatf("v%0d_int", tag), 64'(bus.o_rsp_quot_int), 64'(e_int));
    chk($sformatf("v%0d_frac", tag), 64'(bus.o_rsp_quot_frac), 64'(e_frac));
    chk($sformatf("v%0d_dbz", tag), 64'(bus.o_rsp_dbz), 64'(e_dbz));
    if (stall > 0) begin
      s_mid  = starts;
      stable = 1'b1;
      for (int k = 0; k < stall; k++) begin
        tick();
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_quot_int !== e_int ||
            bus.o_rsp_quot_frac !== e_frac || bus.o_rsp_id !== 2'(id) ||
            bus.o_rsp_dbz !== e_dbz)
          stable = 1'b0;
      end
      chk($sformatf("v%0d_stall_stable", tag), 64'(stable), 64'd1);
      chk($sformatf("v%0d_stall_nostart", tag), 64'(starts - s_mid), 64'd0);
    end
    handshake();
    chk($sformatf("v%0d_valid_drop", tag), 64'(bus.o_rsp_valid), 64'd0);
    chk($sformatf("v%0d_starts", tag), 64'(starts - s0), 64'(e_start));
  endtask

  // --------------------------------------------------------------------------
  typedef struct {
    int           id;
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] e_int;
    logic [Q-1:0] e_frac;
    logic         e_dbz;
    int           e_start;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int              cyc, s0, g3, exp_id;
    bit              seen;
    logic [NREQ-1:0] onehot;

    // 1034/2345: frac = floor(1034*2^33/2345) = 3787630007
    vecs[0] = '{0, 33'd1034, 33'd2345, 33'd0, 33'd3787630007, 1'b0, 1};
    vecs[1] = '{1, 33'd6, 33'd3, 33'd2, 33'd0, 1'b0, 1};
    vecs[2] = '{2, 33'd1, 33'd2, 33'd0, 33'd4294967296, 1'b0, 1};
    vecs[3] = '{3, 33'd7, 33'd2, 33'd3, 33'd4294967296, 1'b0, 1};
    // -9 / 4 = -2.25
    vecs[4] = '{1, 33'h1_0000_0009, 33'd4, 33'h1_0000_0002, 33'd2147483648, 1'b0, 1};
    // 5 / -1 = -5
    vecs[5] = '{2, 33'd5, 33'h1_0000_0001, 33'h1_0000_0005, 33'd0, 1'b0, 1};
    // -5 / +0: saturated, negative
`ifdef DIV_SCHED_DBZ_BYPASS_EN
    vecs[6] = '{0, 33'h1_0000_0005, 33'd0, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b1, 0};
`else
    vecs[6] = '{0, 33'h1_0000_0005, 33'd0, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0, 1};
`endif

    bus.i_req          = '0;
    bus.i_req_dividend = '0;
    bus.i_req_divisor  = '0;
    bus.i_rsp_ready    = 1'b0;

    // ---- reset state ----
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 64'(bus.o_gnt), 64'd0);
    chk("rst_start", 64'(bus.o_div_start), 64'd0);
    chk("rst_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_dbz", 64'(bus.o_rsp_dbz), 64'd0);
    chk("rst_id", 64'(bus.o_rsp_id), 64'd0);
    chk("rst_int", 64'(bus.o_rsp_quot_int), 64'd0);
    chk("rst_frac", 64'(bus.o_rsp_quot_frac), 64'd0);
    chk("rst_dvd", 64'(bus.o_div_dividend), 64'd0);
    chk("rst_dvs", 64'(bus.o_div_divisor), 64'd0);
    rst_n = 1'b1;

    // ---- all four requesting from reset: 0,1,2,3,0 ----
    for (int k = 0; k < NREQ; k++) set_ops(k, N'(k + 1), 33'd1);
    bus.i_req = '1;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % NREQ;
      wait_gnt(cyc);
      onehot         = '0;
      onehot[exp_id] = 1'b1;
      chk($sformatf("rr%0d_gnt", g), 64'(bus.o_gnt), 64'(onehot));
      if (g == 4) bus.i_req = '0;
      wait_valid(cyc);
      chk($sformatf("rr%0d_id", g), 64'(bus.o_rsp_id), 64'(exp_id));
      chk($sformatf("rr%0d_int", g), 64'(bus.o_rsp_quot_int), 64'(exp_id + 1));
      handshake();
    end

    // ---- table ----
    for (int i = 0; i < 7; i++) begin
      run_one(i, vecs[i].id, vecs[i].dvd, vecs[i].dvs, vecs[i].e_int,
              vecs[i].e_frac, vecs[i].e_dbz, vecs[i].e_start, 0);
    end

    // ---- consumer stalls 20 cycles in RESP ----
    run_one(10, 3, 33'd6, 33'd3, 33'd2, 33'd0, 1'b0, 1, 20);

    // ---- request pulsed while busy is dropped; held request waits ----
    g3 = gnt_cnt[3];
    s0 = starts;
    set_ops(1, 33'd6, 33'd3);
    set_ops(3, 33'd9, 33'd1);
    set_ops(0, 33'd8, 33'd2);
    bus.i_req[1] = 1'b1;
    wait_gnt(cyc);
    chk("drop_gnt1", 64'(bus.o_gnt), 64'b0010);
    bus.i_req[1] = 1'b0;
    cyc = 0;
    while (bus.i_div_complete !== 1'b0 && cyc < 50) begin tick(); cyc++; end
    bus.i_req[3] = 1'b1;
    bus.i_req[0] = 1'b1;
    tick();
    tick();
    bus.i_req[3] = 1'b0;
    wait_valid(cyc);
    chk("drop_int", 64'(bus.o_rsp_quot_int), 64'd2);
    handshake();
    wait_gnt(cyc);
    chk("wait_gnt0", 64'(bus.o_gnt), 64'b0001);
    bus.i_req[0] = 1'b0;
    wait_valid(cyc);
    chk("wait_id0", 64'(bus.o_rsp_id), 64'd0);
    chk("wait_int0", 64'(bus.o_rsp_quot_int), 64'd4);
    handshake();
    repeat (10) tick();
    chk("drop_no_gnt3", 64'(gnt_cnt[3] - g3), 64'd0);
    chk("drop_starts", 64'(starts - s0), 64'd2);

    // ---- reset while BUSY ----
    set_ops(2, 33'd100, 33'd3);
    bus.i_req[2] = 1'b1;
    wait_gnt(cyc);
    chk("mrst_gnt", 64'(bus.o_gnt), 64'b0100);
    bus.i_req[2] = 1'b0;
    cyc = 0;
    while (bus.i_div_complete !== 1'b0 && cyc < 50) begin tick(); cyc++; end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_gnt0", 64'(bus.o_gnt), 64'd0);
    chk("mrst_start", 64'(bus.o_div_start), 64'd0);
    chk("mrst_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("mrst_id", 64'(bus.o_rsp_id), 64'd0);
    chk("mrst_int", 64'(bus.o_rsp_quot_int), 64'd0);
    chk("mrst_frac", 64'(bus.o_rsp_quot_frac), 64'd0);
    chk("mrst_dvd", 64'(bus.o_div_dividend), 64'd0);
    chk("mrst_dbz", 64'(bus.o_rsp_dbz), 64'd0);
    s0   = starts;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.o_rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("mrst_no_rsp", 64'(seen), 64'd0);
    chk("mrst_no_start", 64'(starts - s0), 64'd0);

    // ---- scheduler still works after the abandoned transaction ----
    run_one(20, 2, 33'd10, 33'd4, 33'd2, 33'd4294967296, 1'b0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
